wave_capture: RTL and testbench

//  Sample recorder: the write-side counterpart of the ROM waveform generators. Captures an
//  8-bit sample stream into a circular RAM on a rising level-crossing trigger, keeping
//  PRE_TRIG samples from before the trigger. After capture, the buffer is read back in

---
 rtl/wave_pkg.sv | 14 +
 rtl/capture_ram.sv | 40 ++++
 rtl/wave_capture.sv | 158 +++++++++++++++
 tb/tb_wave_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types for the wave_capture sample recorder: FSM state encoding and the
// default sample width.
package wave_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read-first read port.
// Shaped so synthesis maps it onto a block RAM.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array has no reset; resetting it would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // NOTE: non-blocking assignment here is what makes a same-address read return the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wave_capture.sv
// Trigger-aligned sample recorder. Optional input decimation is enabled by defining
// the DECIMATE_EN macro; the default build accepts every valid sample.
module wave_capture
  import wave_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256,
  parameter int DECIM    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int                POST_N     = DEPTH - PRE_TRIG - 1;
  localparam logic [ADDR_W-1:0] PRE_TRIG_A = PRE_TRIG[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] POST_INIT  = POST_N[ADDR_W-1:0];
  localparam bit                NO_POST    = (POST_N == 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [DATA_W-1:0] prev_smp_q, prev_smp_d;
  logic              wr_en;
  logic              acc;
  logic              trig_hit;

`ifdef DECIMATE_EN
  localparam int             DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;

  // The phase counter runs on every valid sample, whatever the capture state.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (arm) begin
      dec_cnt_d = '0;
    end else if (sample_vld) begin
      dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DEC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

  assign acc = sample_vld && (dec_cnt_q == '0);
`else
  logic unused_decim;
  assign unused_decim = (DECIM != 0);
  assign acc          = sample_vld;
`endif

  // Rising crossing: previous accepted sample below the level, current one at or above it.
  assign trig_hit = acc && (pre_cnt_q == PRE_TRIG_A) &&
                    (prev_smp_q < trig_level) && (sample_in >= trig_level);

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    prev_smp_d  = prev_smp_q;
    wr_en       = 1'b0;

    if (arm) begin
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      pre_cnt_d  = '0;
      prev_smp_d = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (acc) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            prev_smp_d = sample_in;
            if (pre_cnt_q != PRE_TRIG_A) begin
              pre_cnt_d = pre_cnt_q + ADDR_W'(1);
            end
            if (trig_hit) begin
              trig_addr_d = wr_ptr_q - PRE_TRIG_A;
              post_cnt_d  = POST_INIT;
              state_d     = NO_POST ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (acc) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            prev_smp_d = sample_in;
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      prev_smp_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      prev_smp_q  <= prev_smp_d;
    end
  end

  assign busy = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done = (state_q == ST_DONE);

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_in),
    .rd_en_i   (rd_en),
    .rd_addr_i (trig_addr_q + rd_addr),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture (DEPTH=16, PRE_TRIG=4): directed scenarios plus
// random streams compared against a sample-history model of the capture window.
module tb_wave_capture;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int PRE_TRIG = 4;
  localparam int DECIM    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_vld = 1'b0;
  logic              arm = 1'b0;
  logic [DATA_W-1:0] trig_level = 8'h80;
  logic              busy, done;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;

  wave_capture #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .PRE_TRIG (PRE_TRIG),
    .DECIM    (DECIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .arm        (arm),
    .trig_level (trig_level),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: full history of accepted samples since arm; the capture window is the DEPTH
  // samples starting PRE_TRIG before the first qualifying rising crossing.
  int hist[$];
  bit m_busy = 0;
  bit m_done = 0;
  int m_trig = -1;
  int m_dec  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_busy = 0; m_done = 0; m_trig = -1; m_dec = 0;
  endtask

  task automatic model_arm();
    hist.delete();
    m_busy = 1; m_done = 0; m_trig = -1; m_dec = 0;
  endtask

  task automatic model_sample(input int s);
    bit taken;
    int idx, prev;
    taken = 1;
`ifdef DECIMATE_EN
    taken = (m_dec == 0);
    m_dec = (m_dec + 1) % DECIM;
`endif
    if (!taken || !m_busy) return;
    hist.push_back(s);
    idx = hist.size() - 1;
    if (m_trig < 0) begin
      prev = (idx == 0) ? 0 : hist[idx-1];
      if (idx >= PRE_TRIG && prev < int'(trig_level) && s >= int'(trig_level)) m_trig = idx;
    end
    if (m_trig >= 0 && hist.size() == m_trig + DEPTH - PRE_TRIG) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  function automatic int exp_at(input int k);
    return hist[m_trig - PRE_TRIG + k];
  endfunction

  task automatic step(input bit v, input int s, input bit a);
    sample_vld = v; sample_in = s[DATA_W-1:0]; arm = a;
    @(posedge clk); #1;
    if (a) model_arm();
    else if (v) model_sample(s);
    sample_vld = 0; arm = 0;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic do_reset();
    rst = 1; sample_vld = 0; arm = 0;
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
  endtask

  task automatic read_at(input int k, input int exp, input string tag);
    rd_addr = k[ADDR_W-1:0]; rd_en = 1;
    @(posedge clk); #1;
    rd_en = 0;
    check(tag, {24'd0, rd_data}, exp);
  endtask

  task automatic read_model_all(input string tag);
    if (!m_done) return;
    for (int k = 0; k < DEPTH; k++) read_at(k, exp_at(k), tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc1, cyc4, n, v;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    do_reset();

    // Scenario 1: ramp in steps of 0x10, trigger on the first crossing at 0x80
    trig_level = 8'h80;
    step(0, 0, 1);
    n = 0;
    while (!m_done && n < 60) begin
      step(1, (n * 16) & 255, 0);
      n++;
    end
    cyc1 = n;
    check("s1_done", {31'd0, done}, 32'd1);
`ifndef DECIMATE_EN
    check("s1_samples", cyc1, 20);
    for (int k = 0; k < DEPTH; k++) read_at(k, ((4 + k) * 16) & 255, "s1_rd");
`endif
    read_model_all("s1_model_rd");
    rd_en = 0;
    @(posedge clk); #1;
    check("rd_hold", {24'd0, rd_data}, exp_at(DEPTH - 1));

    // Scenario 2: crossing during incomplete pre-fill is ignored
    step(0, 0, 1);
    step(1, 8'h90, 0); step(1, 8'h90, 0); step(1, 8'h90, 0);
    step(1, 8'h70, 0); step(1, 8'h85, 0);
    n = 0;
    while (!m_done && n < 80) begin
      step(1, $urandom_range(0, 255), 0);
      n++;
    end
`ifndef DECIMATE_EN
    read_at(4, 8'h85, "s2_trig_sample");
    read_at(0, 8'h90, "s2_oldest");
`endif
    read_model_all("s2_model_rd");

    // Scenario 3: constant full-scale stream never crosses upward
    step(0, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 8'hFF, 0);
    check("s3_busy", {31'd0, busy}, 32'd1);
    check("s3_done", {31'd0, done}, 32'd0);

    // Scenario 4: valid every other cycle gives the same buffer in twice the time
    step(0, 0, 1);
    n = 0; cyc4 = 0;
    while (!m_done && cyc4 < 160) begin
      v = ((cyc4 % 2) == 0) ? 1 : 0;
      step(v[0], (n * 16) & 255, 0);
      if (v != 0) n++;
      cyc4++;
    end
`ifndef DECIMATE_EN
    check("s4_cycles", cyc4, 2 * cyc1 - 1);
    for (int k = 0; k < DEPTH; k++) read_at(k, ((4 + k) * 16) & 255, "s4_rd");
`endif
    read_model_all("s4_model_rd");

    // Scenario 5: re-arm during capture, then reset during capture
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, (i * 16) & 255, 0);
    step(0, 0, 1);
    check("s5_rearm_busy", {31'd0, busy}, 32'd1);
    step(1, 8'h70, 0); step(1, 8'h85, 0);
    step(1, 8'h10, 0); step(1, 8'h20, 0); step(1, 8'h70, 0); step(1, 8'h90, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h40, 0);
    do_reset();
    step(1, 8'h00, 0);
    step(1, 8'hFF, 0);

`ifdef DECIMATE_EN
    // Scenario 6: +1 ramp with decimation stores every DECIM-th value
    step(0, 0, 1);
    n = 0;
    while (!m_done && n < 400) begin
      step(1, n & 255, 0);
      n++;
    end
    read_at(PRE_TRIG, 8'h80, "s6_trig_sample");
    read_at(0, 8'h70, "s6_oldest");
    read_model_all("s6_model_rd");
`endif

    // Random streams with random levels, gaps and read order
    for (int r = 0; r < 8; r++) begin
      trig_level = DATA_W'($urandom_range(8'h20, 8'hE0));
      step(0, 0, 1);
      n = 0;
      while (!m_done && n < 300) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 199) == 0);
        n++;
      end
      if (m_done) begin
        for (int k = 0; k < DEPTH; k++) begin
          v = $urandom_range(0, DEPTH - 1);
          read_at(v, exp_at(v), "rand_rd");
        end
        step(1, $urandom_range(0, 255), 0);
        read_model_all("rand_rd_after_done");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
